debug_dump_sequencer: RTL and testbench

//  Post-halt state dump controller for the MIPS debug path. On request it walks PC, register file and data

---
 rtl/debug_dump_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_debug_dump_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_sequencer.sv
// Post-halt state dump: streams PC, R0..R(N_REGS-1), M0..M(N_MEM_WORDS-1) LSB-first as bytes to UART TX.
// Optional DUMP_CHECKSUM_EN appends one XOR byte over every byte already sent in the frame.
module debug_dump_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int REG_ADDR_W      = 5,
    parameter int N_REGS          = 32,
    parameter int MEM_ADDR_W      = 5,
    parameter int N_MEM_WORDS     = 32
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_dump_req,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic [REG_ADDR_W-1:0]      o_reg_addr,
    input  logic [DATA_WIDTH-1:0]      i_reg_data,
    output logic [MEM_ADDR_W-1:0]      o_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    output logic [DATA_WIDTH_UART-1:0] o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int BYTES       = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int TOTAL_WORDS = 1 + N_REGS + N_MEM_WORDS;
    localparam int WCNT_W      = $clog2(TOTAL_WORDS + 1);
    localparam int BIDX_W      = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [WCNT_W-1:0]     LAST_WORD = WCNT_W'(TOTAL_WORDS - 1);
    localparam logic [WCNT_W-1:0]     REG_END   = WCNT_W'(N_REGS);
    localparam logic [WCNT_W-1:0]     REG_FIRST = WCNT_W'(1);
    localparam logic [WCNT_W-1:0]     MEM_FIRST = WCNT_W'(N_REGS + 1);
    localparam logic [BIDX_W-1:0]     LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [REG_ADDR_W-1:0] REG_LAST  = REG_ADDR_W'(N_REGS - 1);
    localparam logic [MEM_ADDR_W-1:0] MEM_LAST  = MEM_ADDR_W'(N_MEM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_ADDR,
        S_WAIT,
        S_CAPTURE,
`ifdef DUMP_CHECKSUM_EN
        S_CHKSUM,
`endif
        S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [DATA_WIDTH-1:0]     shift;
    logic [WCNT_W-1:0]         word_cnt;
    logic [BIDX_W-1:0]         byte_idx;
    logic [REG_ADDR_W-1:0]     reg_addr;
    logic [MEM_ADDR_W-1:0]     mem_addr;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_WIDTH_UART-1:0] csum;
`endif

    logic accept, last_byte, last_word, reg_phase;

    assign accept     = o_tx_valid & i_tx_ready;
    assign last_byte  = (byte_idx == LAST_BYTE);
    assign last_word  = (word_cnt == LAST_WORD);
    // word 0 is the PC, so register words are indices 1..N_REGS
    assign reg_phase  = (word_cnt <= REG_END);
    assign o_reg_addr = reg_addr;
    assign o_mem_addr = mem_addr;

    always_ff @(posedge i_clock) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (i_dump_req) state_nxt = S_SEND;
            S_SEND: begin
                if (accept && last_byte) begin
                    if (last_word) begin
`ifdef DUMP_CHECKSUM_EN
                        state_nxt = S_CHKSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR:    state_nxt = S_WAIT;
            S_WAIT:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_SEND;
`ifdef DUMP_CHECKSUM_EN
            S_CHKSUM:  if (accept) state_nxt = S_DONE;
`endif
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_valid = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        o_tx_data  = shift[DATA_WIDTH_UART-1:0];
        case (state)
            S_IDLE:   o_busy     = 1'b0;
            S_SEND:   o_tx_valid = 1'b1;
`ifdef DUMP_CHECKSUM_EN
            S_CHKSUM: begin
                o_tx_valid = 1'b1;
                o_tx_data  = csum;
            end
`endif
            S_DONE:   o_done     = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            shift    <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            reg_addr <= '0;
            mem_addr <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_dump_req) begin
                        shift    <= i_pc;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        reg_addr <= '0;
                        mem_addr <= '0;
`ifdef DUMP_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        shift    <= shift >> DATA_WIDTH_UART;
                        byte_idx <= last_byte ? '0 : byte_idx + BIDX_W'(1);
`ifdef DUMP_CHECKSUM_EN
                        csum     <= csum ^ shift[DATA_WIDTH_UART-1:0];
`endif
                        if (last_byte && !last_word)
                            word_cnt <= word_cnt + WCNT_W'(1);
                    end
                end
                // Address counters step once per word and saturate rather than wrap.
                S_ADDR: begin
                    if (reg_phase) begin
                        mem_addr <= '0;
                        if (word_cnt == REG_FIRST)   reg_addr <= '0;
                        else if (reg_addr != REG_LAST) reg_addr <= reg_addr + REG_ADDR_W'(1);
                    end else begin
                        reg_addr <= '0;
                        if (word_cnt == MEM_FIRST)   mem_addr <= '0;
                        else if (mem_addr != MEM_LAST) mem_addr <= mem_addr + MEM_ADDR_W'(1);
                    end
                end
                S_CAPTURE: shift <= reg_phase ? i_reg_data : i_mem_data;
                S_DONE: begin
                    reg_addr <= '0;
                    mem_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: reset, full frame, TX stall, ignored requests, mid-dump reset.
module tb_debug_dump_sequencer;

`ifdef DUMP_CHECKSUM_EN
    localparam int FRAME = 261;
`else
    localparam int FRAME = 260;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_dump_req = 1'b0;
    logic [31:0] i_pc = 32'h0000_0010;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic [4:0]  o_mem_addr;
    logic [31:0] i_mem_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;

    int tests = 0;
    int fails = 0;

    debug_dump_sequencer dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_dump_req(i_dump_req), .i_pc(i_pc),
        .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
        .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    // Combinational debug read ports: Rk = k, Mk = 0x100 + k.
    assign i_reg_data = {27'd0, o_reg_addr};
    assign i_mem_data = 32'h100 + {27'd0, o_mem_addr};

    logic [7:0] rec [0:2047];
    int rec_n = 0;
    int done_n = 0;
    int done_at = 0;

    // Byte recorder: valid&ready seen at the negedge is accepted at the following posedge.
    always @(negedge i_clock) begin
        if (o_tx_valid && i_tx_ready) begin
            if (rec_n < 2048) rec[rec_n] <= o_tx_data;
            rec_n <= rec_n + 1;
        end
        if (o_done) begin
            done_n  <= done_n + 1;
            done_at <= rec_n;
        end
    end

    function automatic logic [7:0] exp_byte(input int n);
        int w, b;
        logic [31:0] v;
        w = n / 4;
        b = n % 4;
        if (w == 0)       v = 32'h10;
        else if (w <= 32) v = 32'(w - 1);
        else              v = 32'h100 + 32'(w - 33);
        return v[8*b +: 8];
    endfunction

    function automatic int count_bad(input int base);
        int bad = 0;
        for (int i = 0; i < 260; i++)
            if (rec[base + i] !== exp_byte(i)) bad++;
        return bad;
    endfunction

    task automatic step;
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_done(input int dn, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (done_n > dn) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b0;
        repeat (3) step();
        i_reset = 1'b1;
        step();
        tests++; if (o_tx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b want=0", o_tx_valid); end
        tests++; if (o_busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%0b want=0", o_busy); end
        tests++; if (o_done !== 1'b0)     begin fails++; $display("FAIL reset_done got=%0b want=0", o_done); end
        tests++; if (o_reg_addr !== 5'd0) begin fails++; $display("FAIL reset_reg_addr got=%0d want=0", o_reg_addr); end
        tests++; if (o_mem_addr !== 5'd0) begin fails++; $display("FAIL reset_mem_addr got=%0d want=0", o_mem_addr); end
    endtask

    task automatic test_full_frame;
        int base, dn, bad;
        bit ok;
        logic [7:0] x;
        base = rec_n; dn = done_n;
        i_tx_ready = 1'b1;
        i_dump_req = 1'b1;
        step();
        i_dump_req = 1'b0;
        tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL start_busy got=%0b want=1", o_busy); end
        tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h10) begin
            fails++; $display("FAIL start_byte got=%0b/%h want=1/10", o_tx_valid, o_tx_data); end
        wait_done(dn, ok);
        tests++; if (!ok) begin fails++; $display("FAIL full_timeout got=no_done want=done"); end
        bad = count_bad(base);
        tests++; if (rec_n - base !== FRAME) begin fails++; $display("FAIL full_count got=%0d want=%0d", rec_n - base, FRAME); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL full_bytes got=%0d_bad want=0_bad", bad); end
        tests++; if (done_n - dn !== 1) begin fails++; $display("FAIL full_done_pulses got=%0d want=1", done_n - dn); end
        tests++; if (done_at - base !== FRAME) begin fails++; $display("FAIL full_done_pos got=%0d want=%0d", done_at - base, FRAME); end
        tests++; if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
            fails++; $display("FAIL full_idle got=busy%0b/valid%0b want=0/0", o_busy, o_tx_valid); end
`ifdef DUMP_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 260; i++) x ^= exp_byte(i);
        tests++; if (rec[base + 260] !== x) begin fails++; $display("FAIL checksum got=%h want=%h", rec[base + 260], x); end
`else
        x = exp_byte(259);
        tests++; if (rec[base + 259] !== x) begin fails++; $display("FAIL last_byte got=%h want=%h", rec[base + 259], x); end
`endif
    endtask

    task automatic test_stall;
        int base, dn, bad, unstable;
        bit stalled, ok;
        logic [7:0] d;
        logic v;
        base = rec_n; dn = done_n; stalled = 1'b0; ok = 1'b0; unstable = 0;
        d = 8'h00; v = 1'b0;
        i_tx_ready = 1'b1;
        i_dump_req = 1'b1;
        step();
        i_dump_req = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            // byte 133 is M0 byte 1 (0x01), mid-word
            if (!stalled && rec_n - base == 133) begin
                stalled = 1'b1;
                d = o_tx_data; v = o_tx_valid;
                i_tx_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    step();
                    if (o_tx_data !== d || o_tx_valid !== 1'b1) unstable++;
                end
                i_tx_ready = 1'b1;
            end
            if (done_n > dn) begin ok = 1'b1; break; end
        end
        bad = count_bad(base);
        tests++; if (!ok) begin fails++; $display("FAIL stall_timeout got=no_done want=done"); end
        tests++; if (v !== 1'b1 || d !== 8'h01) begin fails++; $display("FAIL stall_byte got=%0b/%h want=1/01", v, d); end
        tests++; if (unstable !== 0) begin fails++; $display("FAIL stall_stable got=%0d_changes want=0", unstable); end
        tests++; if (rec_n - base !== FRAME) begin fails++; $display("FAIL stall_count got=%0d want=%0d", rec_n - base, FRAME); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_bytes got=%0d_bad want=0_bad", bad); end
    endtask

    task automatic test_ignore_req;
        int base, dn, n;
        bit p7, p200, got;
        base = rec_n; dn = done_n; p7 = 1'b0; p200 = 1'b0; got = 1'b0;
        i_tx_ready = 1'b1;
        i_dump_req = 1'b1;
        step();
        i_dump_req = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            i_dump_req = 1'b0;
            n = rec_n - base;
            if (o_done) begin
                i_dump_req = 1'b1;
                step();
                i_dump_req = 1'b0;
                got = 1'b1;
                break;
            end
            if (!p7 && n >= 7)     begin p7 = 1'b1;   i_dump_req = 1'b1; end
            if (!p200 && n >= 200) begin p200 = 1'b1; i_dump_req = 1'b1; end
        end
        repeat (20) step();
        tests++; if (!got) begin fails++; $display("FAIL ignore_timeout got=no_done want=done"); end
        tests++; if (rec_n - base !== FRAME) begin fails++; $display("FAIL ignore_count got=%0d want=%0d", rec_n - base, FRAME); end
        tests++; if (done_n - dn !== 1) begin fails++; $display("FAIL ignore_done_pulses got=%0d want=1", done_n - dn); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL ignore_busy got=%0b want=0", o_busy); end
        tests++; if (count_bad(base) !== 0) begin fails++; $display("FAIL ignore_bytes got=%0d_bad want=0_bad", count_bad(base)); end
    endtask

    task automatic test_reset_mid;
        int base, dn;
        bit reached, ok;
        base = rec_n; reached = 1'b0;
        i_tx_ready = 1'b1;
        i_dump_req = 1'b1;
        step();
        i_dump_req = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (rec_n - base >= 50) begin reached = 1'b1; break; end
        end
        tests++; if (!reached) begin fails++; $display("FAIL mid_timeout got=%0d want=50", rec_n - base); end
        i_reset = 1'b0;
        step();
        tests++; if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
            fails++; $display("FAIL mid_abort got=valid%0b/busy%0b want=0/0", o_tx_valid, o_busy); end
        i_reset = 1'b1;
        step();
        base = rec_n; dn = done_n;
        i_dump_req = 1'b1;
        step();
        i_dump_req = 1'b0;
        tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h10) begin
            fails++; $display("FAIL mid_restart got=%0b/%h want=1/10", o_tx_valid, o_tx_data); end
        wait_done(dn, ok);
        tests++; if (!ok || rec_n - base !== FRAME) begin
            fails++; $display("FAIL mid_refill got=%0d want=%0d", rec_n - base, FRAME); end
        tests++; if (count_bad(base) !== 0) begin fails++; $display("FAIL mid_bytes got=%0d_bad want=0_bad", count_bad(base)); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_ignore_req();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
